// File: rtl/wb_unit_pkg.sv
// -----------------------------------------------------------------------------
// wb_unit_pkg
// Shared definitions for the writeback controller:
//   - default bus widths
//   - result-source encodings (wb_src)
//   - load funct3 codes
//   - controller state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package wb_unit_pkg;

    localparam int DATA_WIDTH_DEF      = 32;
    localparam int REG_INDEX_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC4 = 2'd2,
        WB_SRC_IMM = 2'd3
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_WRITE    = 2'd2,
        S_ERR      = 2'd3
    } wb_state_e;

endpackage

// File: rtl/wb_unit_if.sv
// -----------------------------------------------------------------------------
// wb_unit_if
// Bundles the writeback request, the memory load return and the register-file
// write port of wb_unit.
//   master : environment side (control FSM + memory), drives requests and
//            memory data, observes the write port and status pulses.
//   slave  : wb_unit side.
// Signals:
//   wb_start, wb_src[1:0], rd_index, alu_result, pc, imm, funct3[2:0],
//   addr_low[1:0], mem_rdata, mem_valid            (master -> slave)
//   wr_en, wr_reg_index, wr_reg_data, busy, wb_done, wb_err (slave -> master)
// -----------------------------------------------------------------------------
interface wb_unit_if
    import wb_unit_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int REG_INDEX_WIDTH = REG_INDEX_WIDTH_DEF
);

    logic                       wb_start;
    logic [1:0]                 wb_src;
    logic [REG_INDEX_WIDTH-1:0] rd_index;
    logic [DATA_WIDTH-1:0]      alu_result;
    logic [DATA_WIDTH-1:0]      pc;
    logic [DATA_WIDTH-1:0]      imm;
    logic [2:0]                 funct3;
    logic [1:0]                 addr_low;
    logic [DATA_WIDTH-1:0]      mem_rdata;
    logic                       mem_valid;

    logic                       wr_en;
    logic [REG_INDEX_WIDTH-1:0] wr_reg_index;
    logic [DATA_WIDTH-1:0]      wr_reg_data;
    logic                       busy;
    logic                       wb_done;
    logic                       wb_err;

    modport master (
        output wb_start, wb_src, rd_index, alu_result, pc, imm,
               funct3, addr_low, mem_rdata, mem_valid,
        input  wr_en, wr_reg_index, wr_reg_data, busy, wb_done, wb_err
    );

    modport slave (
        input  wb_start, wb_src, rd_index, alu_result, pc, imm,
               funct3, addr_low, mem_rdata, mem_valid,
        output wr_en, wr_reg_index, wr_reg_data, busy, wb_done, wb_err
    );

endinterface

// File: rtl/wb_unit_load_align.sv
// -----------------------------------------------------------------------------
// wb_unit_load_align
// Purely combinational load formatter: picks the byte/half lane addressed by
// addr_low out of the memory word and sign- or zero-extends it according to
// the load funct3. Unknown funct3 codes pass the full word through.
// Ports:
//   mem_rdata [DATA_WIDTH]  raw memory read word
//   funct3    [3]           load type
//   addr_low  [2]           load address bits [1:0]
//   load_data [DATA_WIDTH]  formatted register value
// -----------------------------------------------------------------------------
module wb_unit_load_align
    import wb_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
)(
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_low,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane offsets in bits; half lanes ignore addr_low[0].
    assign byte_sel = mem_rdata[{addr_low, 3'b000} +: 8];
    assign half_sel = mem_rdata[{addr_low[1], 4'b0000} +: 16];

    function automatic logic [DATA_WIDTH-1:0] ext_byte(input logic [7:0] b,
                                                       input logic       sgn);
        logic signed [7:0]            bs;
        logic signed [DATA_WIDTH-1:0] ws;
        bs = $signed(b);
        ws = DATA_WIDTH'(bs);
        return sgn ? ws : DATA_WIDTH'(b);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ext_half(input logic [15:0] h,
                                                       input logic        sgn);
        logic signed [15:0]           hs;
        logic signed [DATA_WIDTH-1:0] ws;
        hs = $signed(h);
        ws = DATA_WIDTH'(hs);
        return sgn ? ws : DATA_WIDTH'(h);
    endfunction

    always_comb begin
        load_data = mem_rdata;
        case (funct3)
            F3_LB:   load_data = ext_byte(byte_sel, 1'b1);
            F3_LBU:  load_data = ext_byte(byte_sel, 1'b0);
            F3_LH:   load_data = ext_half(half_sel, 1'b1);
            F3_LHU:  load_data = ext_half(half_sel, 1'b0);
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// -----------------------------------------------------------------------------
// wb_unit
// Multi-cycle writeback controller driving the register file's single write
// port. A request accepted in IDLE either writes its selected value (ALU,
// PC+4, LUI immediate) on the next cycle, or waits for memory data (bounded by
// MEM_TIMEOUT cycles), formats it and writes it the cycle after mem_valid.
// A write to x0 still completes (wb_done) but keeps wr_en low. A timeout
// pulses wb_err without writing.
// Ports:
//   clk  clock, rising edge
//   rst  synchronous active-high reset
//   bus  wb_unit_if.slave: request, memory return, write port, status
// -----------------------------------------------------------------------------
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int REG_INDEX_WIDTH = REG_INDEX_WIDTH_DEF,
    parameter int MEM_TIMEOUT     = 16
)(
    input  logic     clk,
    input  logic     rst,
    wb_unit_if.slave bus
);

    localparam int               CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    wb_state_e state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // Request fields held for the load path.
    logic [REG_INDEX_WIDTH-1:0] rd_p0;
    logic [2:0]                 funct3_p0;
    logic [1:0]                 addr_low_p0;

    // Registered outputs and their next values.
    logic                       wr_en_p1,   wr_en_n;
    logic [REG_INDEX_WIDTH-1:0] idx_p1,     idx_n;
    logic [DATA_WIDTH-1:0]      data_p1,    data_n;
    logic                       done_p1,    done_n;
    logic                       err_p1,     err_n;

    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  accept;

    wb_unit_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .mem_rdata (bus.mem_rdata),
        .funct3    (funct3_p0),
        .addr_low  (addr_low_p0),
        .load_data (load_data)
    );

    assign accept = (state == S_IDLE) && bus.wb_start;

    // Value for non-memory sources; the MEM arm is never used for a write.
    always_comb begin
        src_data = bus.alu_result;
        case (bus.wb_src)
            WB_SRC_ALU: src_data = bus.alu_result;
            WB_SRC_PC4: src_data = bus.pc + DATA_WIDTH'(4);
            WB_SRC_IMM: src_data = bus.imm;
            default:    src_data = bus.alu_result;
        endcase
    end

    // Request capture stage (data path, not reset).
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_p0       <= bus.rd_index;
            funct3_p0   <= bus.funct3;
            addr_low_p0 <= bus.addr_low;
        end
    end

    // Next state and next registered outputs. The write port is loaded on the
    // transition into WRITE so it appears exactly during the WRITE cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wr_en_n = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        idx_n   = idx_p1;
        data_n  = data_p1;
        case (state)
            S_IDLE: begin
                if (bus.wb_start) begin
                    if (bus.wb_src == WB_SRC_MEM) begin
                        state_n = S_WAIT_MEM;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_WRITE;
                        wr_en_n = (bus.rd_index != '0);
                        done_n  = 1'b1;
                        idx_n   = bus.rd_index;
                        data_n  = src_data;
                    end
                end
            end
            S_WAIT_MEM: begin
                // Data arriving on the final allowed cycle still wins.
                if (bus.mem_valid) begin
                    state_n = S_WRITE;
                    wr_en_n = (rd_p0 != '0);
                    done_n  = 1'b1;
                    idx_n   = rd_p0;
                    data_n  = load_data;
                end else if (cnt == CNT_LAST) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WRITE: state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State and output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wr_en_p1 <= 1'b0;
            idx_p1   <= '0;
            data_p1  <= '0;
            done_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wr_en_p1 <= wr_en_n;
            idx_p1   <= idx_n;
            data_p1  <= data_n;
            done_p1  <= done_n;
            err_p1   <= err_n;
        end
    end

    assign bus.wr_en        = wr_en_p1;
    assign bus.wr_reg_index = idx_p1;
    assign bus.wr_reg_data  = data_p1;
    assign bus.wb_done      = done_p1;
    assign bus.wb_err       = err_p1;
    assign bus.busy         = (state != S_IDLE);

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Multi-cycle writeback controller; the producer side of the register file's single write port.
- Accepts a writeback request from the control FSM and selects the result source: ALU result, memory load, PC+4 or LUI immediate.
- For loads, waits for memory data with a timeout, aligns and sign/zero-extends it, then drives wr_en, wr_reg_index and wr_reg_data for exactly one cycle.

Parameters:
- DATA_WIDTH, 32, width of the register data and operand buses.
- REG_INDEX_WIDTH, 5, width of the destination register index.
- MEM_TIMEOUT, 16, maximum cycles spent in WAIT_MEM before abort (>=2).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_start  input  1  request pulse; sampled only in IDLE.
- wb_src  input  2  result source: 0 ALU, 1 MEM, 2 PC4, 3 IMM.
- rd_index  input  REG_INDEX_WIDTH  destination register.
- alu_result  input  DATA_WIDTH  ALU output.
- pc  input  DATA_WIDTH  current instruction PC.
- imm  input  DATA_WIDTH  U-type immediate, already shifted.
- funct3  input  3  load type.
- addr_low  input  2  load address bits [1:0].
- mem_rdata  input  DATA_WIDTH  memory read word.
- mem_valid  input  1  mem_rdata valid this cycle.
- wr_en  output  1  register file write enable.
- wr_reg_index  output  REG_INDEX_WIDTH  register file write index.
- wr_reg_data  output  DATA_WIDTH  register file write data.
- busy  output  1  high in every state except IDLE.
- wb_done  output  1  one-cycle pulse when writeback completes.
- wb_err  output  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: state IDLE, counter 0; wr_en, wr_reg_index, wr_reg_data, wb_done, wb_err all 0; busy 0. Reset in any state aborts the operation with no write.
- All outputs are registered. busy is decoded from the state register.
- IDLE:
  - On wb_start, capture rd_index, wb_src, funct3 and addr_low.
  - Non-MEM source: capture the selected data (alu_result; pc+4 modulo 2^32; or imm) and go to WRITE.
  - MEM source: clear the counter and go to WAIT_MEM.
  - mem_valid is ignored in IDLE.
- WAIT_MEM:
  - On mem_valid: latch the formatted load data and go to WRITE. mem_valid takes priority over timeout in the same cycle.
  - Otherwise increment the counter. When the counter equals MEM_TIMEOUT-1 without mem_valid, go to ERR.
- WRITE (one cycle, then IDLE):
  - wr_en=1 unless captured rd==0; in that case wr_en=0 and data is discarded.
  - wb_done=1 in both cases.
  - wr_reg_index/wr_reg_data hold their last values outside WRITE; wr_en=0 outside WRITE.
- ERR (one cycle, then IDLE): wb_err=1, wr_en=0, wb_done=0.
- wb_start while busy is ignored; no queuing.
- Latency:
  - Non-MEM: wb_start at cycle N -> wr_en at N+1.
  - MEM: mem_valid at cycle M -> wr_en at M+1.
  - Back-to-back: next wb_start is accepted the cycle after WRITE.
- Load formatting (combinational on mem_rdata, captured addr_low and funct3):
  - 000 LB: byte lane addr_low, sign-extended.
  - 100 LBU: byte lane addr_low, zero-extended.
  - 001 LH: half lane addr_low[1], sign-extended; addr_low[0] ignored.
  - 101 LHU: half lane addr_low[1], zero-extended.
  - 010 LW and all other codes: full word.

Decomposition:
- Shared package holds:
  - WB_SRC_ALU/MEM/PC4/IMM encodings.
  - Load funct3 constants (LB, LH, LW, LBU, LHU).
  - State encoding (IDLE, WAIT_MEM, WRITE, ERR).
  - REG_INDEX_WIDTH/DATA_WIDTH defaults.
- One natural sub-module: load_align (purely combinational lane select and extension), instantiated once.

Test Plan:
- Reset mid-WAIT_MEM:
  - Stimulus: rst=1 for 1 cycle while in WAIT_MEM, then mem_valid.
  - Response: no wr_en; busy=0; all outputs 0.
- ALU writeback:
  - Stimulus: wb_start, src=0, rd=5, alu_result=0xDEADBEEF.
  - Response: next cycle wr_en=1, index=5, data=0xDEADBEEF, wb_done=1; IDLE after.
- Loads with mem_rdata=0x80F17F01:
  - LB, addr_low=3 -> 0xFFFFFF80.
  - LBU, addr_low=2 -> 0x000000F1.
  - LH, addr_low=2 -> 0xFFFF80F1.
  - LHU, addr_low=0 -> 0x00007F01.
  - In each case wr_en comes one cycle after mem_valid.
- PC4 and rd=0:
  - Stimulus: src=2, pc=0xFFFFFFFC, rd=0.
  - Response: wr_en=0, wb_done=1; captured data 0x00000000 (wrap).
- Timeout:
  - Stimulus: src=1, no mem_valid, MEM_TIMEOUT=16.
  - Response: wb_err pulses 16 cycles after the cycle following wb_start; no wr_en.
  - Stimulus: mem_valid on the last WAIT_MEM cycle.
  - Response: write occurs, no wb_err.
- Busy rejection:
  - Stimulus: second wb_start (rd=7) during WAIT_MEM.
  - Response: ignored; only the original rd is written.
